floor_tracker: RTL and testbench
================================

// Module: floor_tracker
// PURPOSE
//  Upstream stage of the Elevator controller. Conditions the per-floor hoistway sensors
//  (in_snsr, out_snsr), tracks car position through a sensor-sequence FSM, and hands the
//  controller a clean registered floor index, an alignment flag, arrive/depart pulses and
//  the travel direction. Detects inconsistent sensor patterns and raises a sticky fault.
// PARAMETERS
//  FLOORS    5  number of landings; sensor vector width
//  FLW       3  width of floor index, >= clog2(FLOORS)
//  DEBOUNCE  2  consecutive stable cycles needed to accept a sensor change; must be >= 1
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       synchronous, active-high
//  in_snsr     in   FLOORS  raw entry sensor per floor; leads on both approach and departure
//  out_snsr    in   FLOORS  raw exit sensor per floor; trails in_snsr
//  floor       out  FLW     last floor at which the car was aligned
//  floor_valid out  1       floor holds a real position
//  aligned     out  1       car level with floor (state ALIGNED)
//  arrive      out  1       1-cycle pulse on entry to ALIGNED from INIT or APPROACH
//  depart      out  1       1-cycle pulse on exit from ALIGNED to LEAVING or BETWEEN
//  travel_dir  out  1       1 = up, 0 = down
//  fault       out  1       sticky sensor-sequence error
// BEHAVIOUR
//  Conditioning, per bit:
//  - 2-flop synchroniser, then a filter; filtered bit fi/fo takes the synchronised value
//    once that value has differed from it for DEBOUNCE consecutive cycles.
//  - A raw change held stable reaches fi/fo exactly 2+DEBOUNCE cycles later.
//  - Shorter glitches are discarded.
//  - FSM and all outputs are registered: outputs react 1 cycle after the fi/fo change,
//    3+DEBOUNCE cycles after the raw change.
//  Reset values: state INIT; floor=0, floor_valid=0, aligned=0, arrive=0, depart=0,
//   travel_dir=1, fault=0; sync and filter flops 0. Reset mid-operation aborts any
//   sequence and returns to these values on the next edge.
//  States, k = tracked floor, j = candidate floor:
//  - INIT: fi[j]&fo[j] for single j -> ALIGNED, floor=j, floor_valid=1, arrive.
//    All other patterns hold INIT.
//  - ALIGNED(k): fi[k] falls, fo[k] still 1 -> LEAVING, depart.
//    fi[k] and fo[k] fall in the same cycle -> BETWEEN, depart.
//    fo[k] falls while fi[k]=1 -> FAULT.
//  - LEAVING(k): fo[k] falls -> BETWEEN. fi[k] rises again -> ALIGNED (reversal),
//    no arrive pulse, floor unchanged.
//  - BETWEEN: fi[j] rises:
//    j=floor+1 -> APPROACH, travel_dir=1. j=floor-1 -> APPROACH, travel_dir=0.
//    j=floor -> APPROACH, travel_dir unchanged. Any other j -> FAULT.
//  - APPROACH(j): fo[j] rises with fi[j]=1 -> ALIGNED, floor=j, arrive.
//    fi[j] falls before fo[j] rises -> BETWEEN, floor unchanged.
//  - FAULT: terminal until reset. fault=1, floor_valid=0, aligned=0, no pulses,
//    floor holds its last value.
//  Global fault checks, any state except INIT:
//  - more than one bit set in fi, or more than one in fo.
//  - fo[m] rises while fi[m]=0 and state is not LEAVING(m).
//  - Fault checks take priority over same-cycle transitions.
//  - Bits 0 and FLOORS-1: no wrap-around; floor-1 from 0 and floor+1 from top are not
//    adjacent and fault.
//  Combinational outputs: aligned = (state==ALIGNED). arrive and depart are never high
//   in the same cycle.
// TESTING  (DEBOUNCE=2, 10-unit clock)
//  1 Reset 10 cycles, sensors 0 -> reset values; then in[0], out[0] 5 cycles later
//    -> arrive pulse 5 cycles after out[0] rise; floor=0, floor_valid=1, aligned=1.
//  2 Up sweep 0->1->2->3 with in-before-out order -> one depart per floor left,
//    arrive at 1, 2, 3; travel_dir=1; final floor=3.
//  3 From aligned at 4, descend to 3 -> depart, travel_dir=0, arrive, floor=3.
//  4 1-cycle glitch on in[2] in BETWEEN -> no state or output change.
//  5 Aligned at 1, leave, raise in[3] -> fault=1, floor_valid=0, stays set;
//    reset asserted -> all reset values next cycle.
//  6 LEAVING(2), re-raise in[2] -> aligned=1, no arrive pulse, floor=2.

Source files
------------

// File: rtl/floor_tracker_if.sv
// floor_tracker_if: hoistway sensor inputs and conditioned position outputs of the floor tracker
interface floor_tracker_if #(parameter int FLOORS = 5, parameter int FLW = 3);
  logic [FLOORS-1:0] in_snsr;
  logic [FLOORS-1:0] out_snsr;
  logic [FLW-1:0] floor;
  logic floor_valid;
  logic aligned;
  logic arrive;
  logic depart;
  logic travel_dir;
  logic fault;
  modport master (
    input in_snsr, out_snsr,
    output floor, floor_valid, aligned, arrive, depart, travel_dir, fault
  );
  modport slave (
    output in_snsr, out_snsr,
    input floor, floor_valid, aligned, arrive, depart, travel_dir, fault
  );
endinterface

// File: rtl/floor_tracker.sv
// floor_tracker: debounces hoistway sensors and tracks car position with a sensor-sequence FSM
module floor_tracker #(
  parameter int FLOORS = 5,
  parameter int FLW = 3,
  parameter int DEBOUNCE = 2
) (
  input logic clk,
  input logic reset,
  floor_tracker_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE - 1);
  typedef enum logic [2:0] {INIT, ALIGNED, LEAVING, BETWEEN, APPROACH, FAULT} state_t;
  state_t state;
  logic [FLOORS-1:0] si1, si2, so1, so2, fi, fo, fi_d, fo_d;
  logic [CW-1:0] ci [FLOORS];
  logic [CW-1:0] co [FLOORS];
  logic [FLOORS-1:0] fi_rise, fi_fall, fo_rise, fo_fall, kmask, cmask;
  logic [FLW-1:0] floor_q, cand, ix, rj;
  logic arrive_q, depart_q, dir_q, multi, bad_fo, gfault;
  always_ff @(posedge clk) begin
    if (reset) begin
      si1 <= '0;
      si2 <= '0;
      so1 <= '0;
      so2 <= '0;
      fi <= '0;
      fo <= '0;
      fi_d <= '0;
      fo_d <= '0;
      for (int i = 0; i < FLOORS; i++) begin
        ci[i] <= '0;
        co[i] <= '0;
      end
    end else begin
      si1 <= bus.in_snsr;
      si2 <= si1;
      so1 <= bus.out_snsr;
      so2 <= so1;
      fi_d <= fi;
      fo_d <= fo;
      // a bit flips only after differing for DEBOUNCE consecutive cycles
      for (int i = 0; i < FLOORS; i++) begin
        ci[i] <= (si2[i] == fi[i] || ci[i] == LIM) ? '0 : ci[i] + CW'(1);
        co[i] <= (so2[i] == fo[i] || co[i] == LIM) ? '0 : co[i] + CW'(1);
        if (si2[i] != fi[i] && ci[i] == LIM) fi[i] <= si2[i];
        if (so2[i] != fo[i] && co[i] == LIM) fo[i] <= so2[i];
      end
    end
  end
  assign fi_rise = fi & ~fi_d;
  assign fi_fall = ~fi & fi_d;
  assign fo_rise = fo & ~fo_d;
  assign fo_fall = ~fo & fo_d;
  assign kmask = {{(FLOORS-1){1'b0}}, 1'b1} << floor_q;
  assign cmask = {{(FLOORS-1){1'b0}}, 1'b1} << cand;
  assign multi = (|(fi & (fi - 1'b1))) || (|(fo & (fo - 1'b1)));
  assign bad_fo = |(fo_rise & ~fi & ~((state == LEAVING) ? kmask : '0));
  assign gfault = (state != INIT) && (multi || bad_fo);
  always_comb begin
    ix = '0;
    rj = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (fi[i]) ix = FLW'(i);
      if (fi_rise[i]) rj = FLW'(i);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      floor_q <= '0;
      cand <= '0;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
      dir_q <= 1'b1;
    end else begin
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
      if (gfault) state <= FAULT;
      else case (state)
        INIT: if (fi == fo && $onehot(fi)) begin
          state <= ALIGNED;
          floor_q <= ix;
          arrive_q <= 1'b1;
        end
        ALIGNED: if (|(fo_fall & kmask & fi)) state <= FAULT;
        else if (|(fi_fall & kmask)) begin
          state <= (|(fo & kmask)) ? LEAVING : BETWEEN;
          depart_q <= 1'b1;
        end
        LEAVING: if (|(fi_rise & kmask)) state <= ALIGNED;
        else if (|(fo_fall & kmask)) state <= BETWEEN;
        // no wrap-around: widened compares keep floor 0 and the top landing non-adjacent
        BETWEEN: if (|fi_rise) begin
          cand <= rj;
          state <= (int'(rj) == int'(floor_q) + 1 || int'(rj) + 1 == int'(floor_q) || rj == floor_q)
                   ? APPROACH : FAULT;
          if (int'(rj) == int'(floor_q) + 1) dir_q <= 1'b1;
          else if (int'(rj) + 1 == int'(floor_q)) dir_q <= 1'b0;
        end
        APPROACH: if (|(fo_rise & cmask & fi)) begin
          state <= ALIGNED;
          floor_q <= cand;
          arrive_q <= 1'b1;
        end else if (|(fi_fall & cmask)) state <= BETWEEN;
        default: state <= FAULT;
      endcase
    end
  end
  assign bus.floor = floor_q;
  assign bus.floor_valid = state inside {ALIGNED, LEAVING, BETWEEN, APPROACH};
  assign bus.aligned = state == ALIGNED;
  assign bus.arrive = arrive_q;
  assign bus.depart = depart_q;
  assign bus.travel_dir = dir_q;
  assign bus.fault = state == FAULT;
endmodule

// File: tb/tb_floor_tracker.sv
// tb_floor_tracker: directed scenario bench for floor_tracker with DEBOUNCE=2
module tb_floor_tracker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int arr_cnt = 0;
  int dep_cnt = 0;
  int both_cnt = 0;
  floor_tracker_if #(.FLOORS(5), .FLW(3)) bus ();
  floor_tracker #(.FLOORS(5), .FLW(3), .DEBOUNCE(2)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.arrive) arr_cnt++;
    if (bus.depart) dep_cnt++;
    if (bus.arrive && bus.depart) both_cnt++;
  end
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_in(input int f, input logic v);
    bus.in_snsr[f] = v;
    wait_n(8);
  endtask
  task automatic set_out(input int f, input logic v);
    bus.out_snsr[f] = v;
    wait_n(8);
  endtask
  task automatic move(input int from, input int to);
    set_in(from, 1'b0);
    set_out(from, 1'b0);
    set_in(to, 1'b1);
    set_out(to, 1'b1);
  endtask
  task automatic test_reset;
    reset = 1'b1;
    bus.in_snsr = '0;
    bus.out_snsr = '0;
    wait_n(10);
    total += 7;
    if (bus.floor !== 3'd0) begin bad++; $display("FAIL reset_floor got=%0d want=0", bus.floor); end
    if (bus.floor_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.floor_valid); end
    if (bus.aligned !== 1'b0) begin bad++; $display("FAIL reset_aligned got=%b want=0", bus.aligned); end
    if (bus.arrive !== 1'b0) begin bad++; $display("FAIL reset_arrive got=%b want=0", bus.arrive); end
    if (bus.depart !== 1'b0) begin bad++; $display("FAIL reset_depart got=%b want=0", bus.depart); end
    if (bus.travel_dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%b want=1", bus.travel_dir); end
    if (bus.fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", bus.fault); end
    reset = 1'b0;
    wait_n(2);
  endtask
  task automatic test_init_align;
    bus.in_snsr[0] = 1'b1;
    wait_n(5);
    total++;
    if (bus.aligned !== 1'b0) begin bad++; $display("FAIL init_in_only aligned got=%b want=0", bus.aligned); end
    bus.out_snsr[0] = 1'b1;
    wait_n(4);
    total++;
    if (bus.arrive !== 1'b0) begin bad++; $display("FAIL init_early_arrive got=%b want=0", bus.arrive); end
    wait_n(1);
    total += 4;
    if (bus.arrive !== 1'b1) begin bad++; $display("FAIL init_arrive got=%b want=1", bus.arrive); end
    if (bus.aligned !== 1'b1) begin bad++; $display("FAIL init_aligned got=%b want=1", bus.aligned); end
    if (bus.floor_valid !== 1'b1) begin bad++; $display("FAIL init_valid got=%b want=1", bus.floor_valid); end
    if (bus.floor !== 3'd0) begin bad++; $display("FAIL init_floor got=%0d want=0", bus.floor); end
    wait_n(1);
    total++;
    if (bus.arrive !== 1'b0) begin bad++; $display("FAIL init_arrive_width got=%b want=0", bus.arrive); end
    wait_n(4);
  endtask
  task automatic test_up_sweep;
    for (int f = 0; f < 3; f++) begin
      int a0, d0;
      a0 = arr_cnt;
      d0 = dep_cnt;
      move(f, f + 1);
      total += 5;
      if (bus.floor !== 3'(f + 1)) begin bad++; $display("FAIL up_floor got=%0d want=%0d", bus.floor, f + 1); end
      if (bus.aligned !== 1'b1) begin bad++; $display("FAIL up_aligned got=%b want=1", bus.aligned); end
      if (bus.travel_dir !== 1'b1) begin bad++; $display("FAIL up_dir got=%b want=1", bus.travel_dir); end
      if (arr_cnt - a0 !== 1) begin bad++; $display("FAIL up_arrivals got=%0d want=1", arr_cnt - a0); end
      if (dep_cnt - d0 !== 1) begin bad++; $display("FAIL up_departs got=%0d want=1", dep_cnt - d0); end
    end
    total++;
    if (bus.floor !== 3'd3) begin bad++; $display("FAIL up_final got=%0d want=3", bus.floor); end
  endtask
  task automatic test_descend;
    int a0, d0;
    move(3, 4);
    total++;
    if (bus.floor !== 3'd4) begin bad++; $display("FAIL top_floor got=%0d want=4", bus.floor); end
    a0 = arr_cnt;
    d0 = dep_cnt;
    move(4, 3);
    total += 5;
    if (bus.floor !== 3'd3) begin bad++; $display("FAIL down_floor got=%0d want=3", bus.floor); end
    if (bus.travel_dir !== 1'b0) begin bad++; $display("FAIL down_dir got=%b want=0", bus.travel_dir); end
    if (bus.aligned !== 1'b1) begin bad++; $display("FAIL down_aligned got=%b want=1", bus.aligned); end
    if (arr_cnt - a0 !== 1) begin bad++; $display("FAIL down_arrivals got=%0d want=1", arr_cnt - a0); end
    if (dep_cnt - d0 !== 1) begin bad++; $display("FAIL down_departs got=%0d want=1", dep_cnt - d0); end
  endtask
  task automatic test_glitch;
    int a0, d0;
    set_in(3, 1'b0);
    set_out(3, 1'b0);
    total += 2;
    if (bus.floor_valid !== 1'b1) begin bad++; $display("FAIL between_valid got=%b want=1", bus.floor_valid); end
    if (bus.aligned !== 1'b0) begin bad++; $display("FAIL between_aligned got=%b want=0", bus.aligned); end
    a0 = arr_cnt;
    d0 = dep_cnt;
    bus.in_snsr[2] = 1'b1;
    wait_n(1);
    bus.in_snsr[2] = 1'b0;
    wait_n(8);
    total += 6;
    if (arr_cnt !== a0 || dep_cnt !== d0) begin bad++; $display("FAIL glitch_pulses got=%0d/%0d want=%0d/%0d", arr_cnt, dep_cnt, a0, d0); end
    if (bus.floor !== 3'd3) begin bad++; $display("FAIL glitch_floor got=%0d want=3", bus.floor); end
    if (bus.fault !== 1'b0) begin bad++; $display("FAIL glitch_fault got=%b want=0", bus.fault); end
    if (bus.floor_valid !== 1'b1) begin bad++; $display("FAIL glitch_valid got=%b want=1", bus.floor_valid); end
    if (bus.aligned !== 1'b0) begin bad++; $display("FAIL glitch_aligned got=%b want=0", bus.aligned); end
    if (bus.travel_dir !== 1'b0) begin bad++; $display("FAIL glitch_dir got=%b want=0", bus.travel_dir); end
    set_in(2, 1'b1);
    set_out(2, 1'b1);
    total++;
    if (bus.floor !== 3'd2 || bus.aligned !== 1'b1) begin bad++; $display("FAIL glitch_resume got=%0d/%b want=2/1", bus.floor, bus.aligned); end
  endtask
  task automatic test_reversal;
    int a0, d0;
    a0 = arr_cnt;
    d0 = dep_cnt;
    set_in(2, 1'b0);
    total += 2;
    if (bus.aligned !== 1'b0) begin bad++; $display("FAIL leaving_aligned got=%b want=0", bus.aligned); end
    if (dep_cnt - d0 !== 1) begin bad++; $display("FAIL leaving_depart got=%0d want=1", dep_cnt - d0); end
    set_in(2, 1'b1);
    total += 4;
    if (bus.aligned !== 1'b1) begin bad++; $display("FAIL reversal_aligned got=%b want=1", bus.aligned); end
    if (arr_cnt !== a0) begin bad++; $display("FAIL reversal_arrive got=%0d want=%0d", arr_cnt, a0); end
    if (bus.floor !== 3'd2) begin bad++; $display("FAIL reversal_floor got=%0d want=2", bus.floor); end
    if (bus.fault !== 1'b0) begin bad++; $display("FAIL reversal_fault got=%b want=0", bus.fault); end
  endtask
  task automatic test_fault;
    move(2, 1);
    total++;
    if (bus.floor !== 3'd1 || bus.travel_dir !== 1'b0) begin bad++; $display("FAIL pre_fault got=%0d/%b want=1/0", bus.floor, bus.travel_dir); end
    set_in(1, 1'b0);
    set_out(1, 1'b0);
    set_in(3, 1'b1);
    total += 4;
    if (bus.fault !== 1'b1) begin bad++; $display("FAIL skip_fault got=%b want=1", bus.fault); end
    if (bus.floor_valid !== 1'b0) begin bad++; $display("FAIL skip_valid got=%b want=0", bus.floor_valid); end
    if (bus.aligned !== 1'b0) begin bad++; $display("FAIL skip_aligned got=%b want=0", bus.aligned); end
    if (bus.floor !== 3'd1) begin bad++; $display("FAIL skip_floor got=%0d want=1", bus.floor); end
    set_in(3, 1'b0);
    set_out(3, 1'b1);
    total++;
    if (bus.fault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b want=1", bus.fault); end
    reset = 1'b1;
    bus.in_snsr = '0;
    bus.out_snsr = '0;
    wait_n(1);
    total += 4;
    if (bus.fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b want=0", bus.fault); end
    if (bus.floor !== 3'd0) begin bad++; $display("FAIL rst_floor got=%0d want=0", bus.floor); end
    if (bus.floor_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.floor_valid); end
    if (bus.travel_dir !== 1'b1) begin bad++; $display("FAIL rst_dir got=%b want=1", bus.travel_dir); end
    reset = 1'b0;
    wait_n(2);
  endtask
  initial begin
    bus.in_snsr = '0;
    bus.out_snsr = '0;
    test_reset();
    test_init_align();
    test_up_sweep();
    test_descend();
    test_glitch();
    test_reversal();
    test_fault();
    total++;
    if (both_cnt !== 0) begin bad++; $display("FAIL arrive_depart_overlap got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
